// File: rtl/branch_predictor.sv
// Purpose    : gshare direction predictor; predicts fetch branches, carries the
//              prediction F->D->E, and trains 2-bit counters plus global history at E.
// Latency    : pred_take_F is combinational from pc_F; training lands on the clock edge
//              after a valid E-stage branch.
// Backpressure: stall_D/stall_E hold their pipeline stage; a stalled E-stage branch
//              does not train until the stall drops, so each branch trains exactly once.
//
// Ports:
//   clk, rst          - clock; synchronous active-low reset
//   pc_F, branch_F    - fetch PC and "fetch instruction is a conditional branch"
//   stall_D, flush_D  - hold / clear the F/D prediction register
//   stall_E, flush_E  - hold / clear the D/E prediction register (flush wins)
//   branch_E          - E-stage instruction is a conditional branch
//   actual_take_E     - resolved direction at E
//   pred_take_F       - predicted taken for the fetch branch
//   pred_take_E       - prediction carried to E
//   pre_right         - E-stage prediction matched the resolved direction
//   init_busy         - counter table initialisation in progress
module branch_predictor #(
    parameter int         IDX_W    = 10,
    parameter int         GHR_W    = 8,
    parameter logic [1:0] INIT_CNT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_F,
    input  logic        branch_F,
    input  logic        stall_D,
    input  logic        flush_D,
    input  logic        stall_E,
    input  logic        flush_E,
    input  logic        branch_E,
    input  logic        actual_take_E,
    output logic        pred_take_F,
    output logic        pred_take_E,
    output logic        pre_right,
    output logic        init_busy
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One prediction in flight: is it a branch, what we predicted, which counter.
    typedef struct packed {
        logic             vld;
        logic             pred;
        logic [IDX_W-1:0] idx;
    } pipe_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] init_ptr_q;
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_shift;
    logic [1:0]       pht [DEPTH];

    pipe_t            fd_q;
    pipe_t            fd_nxt;
    pipe_t            de_q;

    logic [IDX_W-1:0] ghr_idx;
    logic [IDX_W-1:0] idx_f;
    logic [1:0]       cnt_f;
    logic [1:0]       cnt_e;
    logic [1:0]       cnt_new;
    logic             init_we;
    logic             train_en;
    logic             unused_bits;

    // ------------------------------------------------------------------
    // Init / run FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                init_ptr_q <= init_ptr_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        init_busy = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_busy = 1'b1;
                // Last entry is written this cycle; run from the next one.
                if (&init_ptr_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch-side lookup
    // ------------------------------------------------------------------
    // History is zero-extended into the low bits of the index before the XOR.
    always_comb begin
        ghr_idx              = '0;
        ghr_idx[GHR_W-1:0]   = ghr_q;
    end

    assign idx_f       = pc_F[IDX_W+1:2] ^ ghr_idx;
    assign cnt_f       = pht[idx_f];
    assign pred_take_F = branch_F & cnt_f[1] & ~init_busy;

    // PC alignment bits, PC bits above the index, and the counter's weak/strong
    // bit play no part in the fetch prediction.
    assign unused_bits = ^{pc_F[31:IDX_W+2], pc_F[1:0], cnt_f[0]};

    // ------------------------------------------------------------------
    // F/D and D/E prediction registers
    // ------------------------------------------------------------------
    always_comb begin
        fd_nxt      = '0;
        fd_nxt.vld  = branch_F;
        fd_nxt.pred = pred_take_F;
        fd_nxt.idx  = idx_f;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fd_q <= '0;
        end else if (flush_D) begin
            fd_q <= '0;
        end else if (!stall_D) begin
            fd_q <= fd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            de_q <= '0;
        end else if (flush_E) begin
            de_q <= '0;
        end else if (!stall_E) begin
            de_q <= fd_q;
        end
    end

    assign pred_take_E = de_q.pred;
    assign pre_right   = branch_E & de_q.vld & (de_q.pred == actual_take_E);

    // ------------------------------------------------------------------
    // Training
    // ------------------------------------------------------------------
    // rst is folded in so a reset edge drops any training that would
    // otherwise have landed on that same edge.
    assign train_en = rst & (state_q == ST_RUN) & branch_E & de_q.vld & ~stall_E;
    assign init_we  = rst & (state_q == ST_INIT);

    assign cnt_e = pht[de_q.idx];

    always_comb begin
        cnt_new = cnt_e;
        if (actual_take_E) begin
            if (cnt_e != 2'b11) begin
                cnt_new = cnt_e + 2'd1;
            end
        end else begin
            if (cnt_e != 2'b00) begin
                cnt_new = cnt_e - 2'd1;
            end
        end
    end

    // Shift-in works for any GHR_W >= 1, including a single-bit history.
    always_comb begin
        ghr_shift    = ghr_q << 1;
        ghr_shift[0] = actual_take_E;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ghr_q <= '0;
        end else if (train_en) begin
            ghr_q <= ghr_shift;
        end
    end

    // Table has no reset; the INIT sweep gives every entry a defined value.
    // The fetch read above sees the old value in a write cycle (read-old).
    always_ff @(posedge clk) begin
        if (init_we) begin
            pht[init_ptr_q] <= INIT_CNT;
        end else if (train_en) begin
            pht[de_q.idx] <= cnt_new;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int IDX_W = 4;
    localparam int GHR_W = 1;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_F;
    logic        branch_F;
    logic        stall_D;
    logic        flush_D;
    logic        stall_E;
    logic        flush_E;
    logic        branch_E;
    logic        actual_take_E;
    logic        pred_take_F;
    logic        pred_take_E;
    logic        pre_right;
    logic        init_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the table and history, plus the in-flight scoreboard.
    logic [1:0] m_pht [DEPTH];
    logic       m_ghr;
    logic       sb_pred[$];
    logic [3:0] sb_idx[$];

    typedef struct packed {
        logic       pf;
        logic       pe;
        logic       pr;
        logic [1:0] cnt;
        logic       ghr;
    } obs_t;

    always #5 clk = ~clk;

    branch_predictor #(
        .IDX_W   (IDX_W),
        .GHR_W   (GHR_W),
        .INIT_CNT(2'b01)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_F         (pc_F),
        .branch_F     (branch_F),
        .stall_D      (stall_D),
        .flush_D      (flush_D),
        .stall_E      (stall_E),
        .flush_E      (flush_E),
        .branch_E     (branch_E),
        .actual_take_E(actual_take_E),
        .pred_take_F  (pred_take_F),
        .pred_take_E  (pred_take_E),
        .pre_right    (pre_right),
        .init_busy    (init_busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [3:0] model_idx(input logic [31:0] pc);
        return pc[5:2] ^ {3'b000, m_ghr};
    endfunction

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
        return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_pht[i] = 2'b01;
        m_ghr = 1'b0;
        sb_pred.delete();
        sb_idx.delete();
    endtask

    // Present a branch at F and record what the model says it should predict.
    task automatic push_f(input logic [31:0] pc);
        logic [3:0] i;
        i        = model_idx(pc);
        pc_F     = pc;
        branch_F = 1'b1;
        sb_idx.push_back(i);
        sb_pred.push_back(m_pht[i][1]);
    endtask

    // Send one branch F->D->E with no stalls and collect observations.
    task automatic run_one(input logic [31:0] pc, input logic act, output obs_t o);
        logic       ep;
        logic [3:0] i;
        o = '0;
        push_f(pc);
        @(negedge clk);
        o.pf = pred_take_F;
        cyc();
        branch_F = 1'b0;
        cyc();
        branch_E      = 1'b1;
        actual_take_E = act;
        @(negedge clk);
        ep   = sb_pred.pop_front();
        i    = sb_idx.pop_front();
        o.pe = pred_take_E;
        o.pr = pre_right;
        if (o.pe !== ep) begin
            $display("FAIL sb_pred_E: got %0b expected %0b", o.pe, ep);
            n_fail++;
        end
        n_tests++;
        cyc();
        branch_E = 1'b0;
        m_pht[i] = sat(m_pht[i], act);
        m_ghr    = act;
        o.cnt    = dut.pht[i];
        o.ghr    = dut.ghr_q;
    endtask

    task automatic test_reset();
        int cnt;
        int bad;
        rst = 1'b0; branch_F = 1'b0; pc_F = 32'h0; stall_D = 1'b0; flush_D = 1'b0;
        stall_E = 1'b0; flush_E = 1'b0; branch_E = 1'b1; actual_take_E = 1'b0;
        cyc();
        cyc();
        n_tests++;
        if (init_busy !== 1'b1) begin
            $display("FAIL reset_busy: got %0b expected 1", init_busy); n_fail++;
        end
        n_tests++;
        if (pred_take_E !== 1'b0) begin
            $display("FAIL reset_pred_E: got %0b expected 0", pred_take_E); n_fail++;
        end
        n_tests++;
        if (pre_right !== 1'b0) begin
            $display("FAIL reset_pre_right: got %0b expected 0", pre_right); n_fail++;
        end
        branch_E = 1'b0;
        rst      = 1'b1;
        branch_F = 1'b1;
        pc_F     = 32'h0000_3000;
        cnt      = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_tests++;
                if (pred_take_F !== 1'b0) begin
                    $display("FAIL init_pred_F: got %0b expected 0", pred_take_F); n_fail++;
                end
            end
            if (init_busy !== 1'b1) break;
            cnt++;
            cyc();
        end
        cyc();
        n_tests++;
        if (cnt != 16) begin
            $display("FAIL init_cycles: got %0d expected 16", cnt); n_fail++;
        end
        branch_F = 1'b0;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (dut.pht[i] !== 2'b01) bad++;
        n_tests++;
        if (bad != 0) begin
            $display("FAIL init_table: %0d entries differ from 01, expected 0", bad); n_fail++;
        end
        cyc();
        cyc();
        model_reset();
    endtask

    task automatic test_mispredict();
        obs_t o;
        run_one(32'h0000_3000, 1'b1, o);
        n_tests++;
        if (o.pf !== 1'b0) begin $display("FAIL mis_pred_F: got %0b expected 0", o.pf); n_fail++; end
        n_tests++;
        if (o.pe !== 1'b0) begin $display("FAIL mis_pred_E: got %0b expected 0", o.pe); n_fail++; end
        n_tests++;
        if (o.pr !== 1'b0) begin $display("FAIL mis_pre_right: got %0b expected 0", o.pr); n_fail++; end
        n_tests++;
        if (o.cnt !== 2'b10) begin $display("FAIL mis_cnt: got %0b expected 10", o.cnt); n_fail++; end
        n_tests++;
        if (o.ghr !== 1'b1) begin $display("FAIL mis_ghr: got %0b expected 1", o.ghr); n_fail++; end
    endtask

    // Continues from the mispredict: GHR=1 steers the taken run onto entry 1,
    // the not-taken run walks entry 1 down, then entry 0 down.
    task automatic test_saturation();
        obs_t       o;
        logic       acts   [6];
        logic       exp_pf [6];
        logic       exp_pr [6];
        logic [1:0] exp_cnt[6];
        acts    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_pf  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_pr  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_cnt = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
        for (int k = 0; k < 6; k++) begin
            run_one(32'h0000_3000, acts[k], o);
            n_tests++;
            if (o.pf !== exp_pf[k]) begin
                $display("FAIL sat_pred_F[%0d]: got %0b expected %0b", k, o.pf, exp_pf[k]); n_fail++;
            end
            n_tests++;
            if (o.pr !== exp_pr[k]) begin
                $display("FAIL sat_pre_right[%0d]: got %0b expected %0b", k, o.pr, exp_pr[k]); n_fail++;
            end
            n_tests++;
            if (o.cnt !== exp_cnt[k]) begin
                $display("FAIL sat_cnt[%0d]: got %0b expected %0b", k, o.cnt, exp_cnt[k]); n_fail++;
            end
            n_tests++;
            if (o.ghr !== acts[k]) begin
                $display("FAIL sat_ghr[%0d]: got %0b expected %0b", k, o.ghr, acts[k]); n_fail++;
            end
        end
    endtask

    task automatic test_correct();
        obs_t o;
        // Entry 1 is 10 with GHR=0: predicts taken, becomes 11.
        run_one(32'h0000_3004, 1'b1, o);
        n_tests++;
        if (o.pe !== 1'b1 || o.pr !== 1'b1 || o.cnt !== 2'b11) begin
            $display("FAIL correct_a: got pe=%0b pr=%0b cnt=%0b expected pe=1 pr=1 cnt=11", o.pe, o.pr, o.cnt);
            n_fail++;
        end
        // GHR=1 maps 0x3000 onto entry 1 again: stays saturated at 11.
        run_one(32'h0000_3000, 1'b1, o);
        n_tests++;
        if (o.pe !== 1'b1 || o.pr !== 1'b1 || o.cnt !== 2'b11) begin
            $display("FAIL correct_b: got pe=%0b pr=%0b cnt=%0b expected pe=1 pr=1 cnt=11", o.pe, o.pr, o.cnt);
            n_fail++;
        end
    endtask

    task automatic test_stall_flush();
        logic       ep;
        logic [3:0] i;
        // GHR=1: 0x3008 -> entry 3 (01), predicts not-taken, resolves not-taken.
        push_f(32'h0000_3008);
        cyc();
        branch_F = 1'b0;
        cyc();
        branch_E = 1'b1; actual_take_E = 1'b0; stall_E = 1'b1;
        @(negedge clk);
        ep = sb_pred.pop_front();
        i  = sb_idx.pop_front();
        n_tests++;
        if (pre_right !== (ep == 1'b0)) begin
            $display("FAIL stall_pre_right_first: got %0b expected %0b", pre_right, (ep == 1'b0)); n_fail++;
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_tests++;
            if (pre_right !== 1'b1 || dut.pht[i] !== 2'b01) begin
                $display("FAIL stall_hold[%0d]: got pr=%0b cnt=%0b expected pr=1 cnt=01", k, pre_right, dut.pht[i]);
                n_fail++;
            end
        end
        stall_E = 1'b0;
        cyc();
        m_pht[i] = sat(m_pht[i], 1'b0);
        m_ghr    = 1'b0;
        n_tests++;
        if (dut.pht[i] !== 2'b00) begin
            $display("FAIL stall_release_cnt: got %0b expected 00", dut.pht[i]); n_fail++;
        end
        cyc();
        n_tests++;
        if (dut.pht[i] !== m_pht[i] || dut.ghr_q !== m_ghr) begin
            $display("FAIL stall_single_update: got cnt=%0b ghr=%0b expected cnt=%0b ghr=%0b",
                     dut.pht[i], dut.ghr_q, m_pht[i], m_ghr);
            n_fail++;
        end
        branch_E = 1'b0;

        // GHR=0: 0x3008 -> entry 2 (01). Flush together with stall at E.
        push_f(32'h0000_3008);
        cyc();
        branch_F = 1'b0;
        cyc();
        branch_E = 1'b1; actual_take_E = 1'b1; stall_E = 1'b1; flush_E = 1'b1;
        @(negedge clk);
        ep = sb_pred.pop_front();
        i  = sb_idx.pop_front();
        n_tests++;
        if (pre_right !== (ep == 1'b1)) begin
            $display("FAIL flush_pre_right_before: got %0b expected %0b", pre_right, (ep == 1'b1)); n_fail++;
        end
        cyc();
        stall_E = 1'b0; flush_E = 1'b0; actual_take_E = 1'b0;
        @(negedge clk);
        // pred_E is now 0 and matches actual 0, so only valid_E keeps this low.
        n_tests++;
        if (pre_right !== 1'b0) begin
            $display("FAIL flush_pre_right_after: got %0b expected 0", pre_right); n_fail++;
        end
        cyc();
        n_tests++;
        if (dut.pht[i] !== m_pht[i] || dut.ghr_q !== m_ghr) begin
            $display("FAIL flush_no_train: got cnt=%0b ghr=%0b expected cnt=%0b ghr=%0b",
                     dut.pht[i], dut.ghr_q, m_pht[i], m_ghr);
            n_fail++;
        end
        branch_E = 1'b0;
        cyc();
    endtask

    task automatic test_collision();
        logic [31:0] p;
        logic [31:0] p2;
        logic        ep;
        logic [3:0]  i;
        p       = 32'h0000_4000;
        p[5:2]  = 4'd5 ^ {3'b000, m_ghr};
        push_f(p);
        cyc();
        branch_F = 1'b0;
        cyc();
        branch_E = 1'b1; actual_take_E = 1'b1;
        pc_F = p; branch_F = 1'b1; flush_D = 1'b1;
        @(negedge clk);
        ep = sb_pred.pop_front();
        i  = sb_idx.pop_front();
        n_tests++;
        if (pred_take_F !== 1'b0) begin
            $display("FAIL collide_same_cycle: got %0b expected 0", pred_take_F); n_fail++;
        end
        n_tests++;
        if (pre_right !== (ep == 1'b1)) begin
            $display("FAIL collide_pre_right: got %0b expected %0b", pre_right, (ep == 1'b1)); n_fail++;
        end
        cyc();
        m_pht[i] = sat(m_pht[i], 1'b1);
        m_ghr    = 1'b1;
        branch_E = 1'b0;
        p2       = 32'h0000_4000;
        p2[5:2]  = 4'd5 ^ {3'b000, m_ghr};
        pc_F     = p2;
        @(negedge clk);
        n_tests++;
        if (dut.pht[5] !== 2'b10) begin
            $display("FAIL collide_cnt: got %0b expected 10", dut.pht[5]); n_fail++;
        end
        n_tests++;
        if (pred_take_F !== 1'b1) begin
            $display("FAIL collide_next_cycle: got %0b expected 1", pred_take_F); n_fail++;
        end
        cyc();
        branch_F = 1'b0; flush_D = 1'b0;
        cyc();
    endtask

    task automatic test_mid_reset();
        logic       ep;
        logic [3:0] i;
        int         cnt;
        int         bad;
        push_f(32'h0000_3008);
        cyc();
        branch_F = 1'b0;
        cyc();
        branch_E = 1'b1; actual_take_E = 1'b1; rst = 1'b0;
        @(negedge clk);
        ep = sb_pred.pop_front();
        i  = sb_idx.pop_front();
        cyc();
        n_tests++;
        if (init_busy !== 1'b1) begin
            $display("FAIL midrst_busy: got %0b expected 1", init_busy); n_fail++;
        end
        n_tests++;
        if (dut.pht[i] !== m_pht[i] || dut.ghr_q !== 1'b0) begin
            $display("FAIL midrst_no_train: got cnt=%0b ghr=%0b expected cnt=%0b ghr=0 (pred %0b)",
                     dut.pht[i], dut.ghr_q, m_pht[i], ep);
            n_fail++;
        end
        n_tests++;
        if (pre_right !== 1'b0) begin
            $display("FAIL midrst_pre_right: got %0b expected 0", pre_right); n_fail++;
        end
        branch_E = 1'b0;
        rst      = 1'b1;
        model_reset();
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (init_busy !== 1'b1) break;
            cnt++;
            cyc();
        end
        cyc();
        n_tests++;
        if (cnt != 16) begin
            $display("FAIL midrst_init_cycles: got %0d expected 16", cnt); n_fail++;
        end
        bad = 0;
        for (int k = 0; k < DEPTH; k++) if (dut.pht[k] !== 2'b01) bad++;
        n_tests++;
        if (bad != 0) begin
            $display("FAIL midrst_table: %0d entries differ from 01, expected 0", bad); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_saturation();
        test_correct();
        test_stall_flush();
        test_collision();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Gshare direction predictor feeding the fetch-stage PC select logic.
- Produces pred_take_F for the branch in fetch.
- Carries each prediction and its table index down the F->D->E pipeline.
- At E, reports whether the prediction was right (pre_right) and trains a 2-bit saturating counter table plus a global history register.

Parameters:
IDX_W, 10, PHT index width; table depth = 2**IDX_W entries
GHR_W, 8, global history length (GHR_W <= IDX_W)
INIT_CNT, 2'b01, counter value written at init (weakly not-taken)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-low reset
pc_F  in  32  fetch PC
branch_F  in  1  fetch instruction is a conditional branch
stall_D  in  1  hold F/D prediction register
flush_D  in  1  clear F/D prediction register
stall_E  in  1  hold D/E prediction register; blocks training
flush_E  in  1  clear D/E prediction register
branch_E  in  1  E-stage instruction is a conditional branch
actual_take_E  in  1  resolved branch direction at E
pred_take_F  out  1  predicted taken for fetch branch
pred_take_E  out  1  prediction carried to E
pre_right  out  1  E-stage prediction matched outcome
init_busy  out  1  table initialisation in progress

Behaviour:
- Reset: rst==0 at a rising edge puts the FSM in INIT and sets init_ptr=0, GHR=0, and all pipeline registers (valid, pred, idx) to 0. Reset applies identically mid-operation: any in-flight training is dropped.
- FSM INIT: each cycle writes PHT[init_ptr]=INIT_CNT, then init_ptr+1.
  - When init_ptr==2**IDX_W-1 is written, go to RUN next cycle.
  - INIT lasts exactly 2**IDX_W cycles after rst deasserts.
  - init_busy=1 in INIT, 0 in RUN.
- In INIT: pred_take_F=0, training suppressed, GHR held. Pipeline registers still advance with the 0 predictions.
- Index: idx_F = pc_F[IDX_W+1:2] XOR zero-extended GHR in the low GHR_W bits.
- pred_take_F = branch_F & PHT[idx_F][1] & ~init_busy. Combinational; no added latency.
- F/D register {valid_D, pred_D, idx_D}, each edge:
  - if flush_D, clear;
  - else if ~stall_D, load {branch_F, pred_take_F, idx_F};
  - else hold.
- D/E register {valid_E, pred_E, idx_E}, each edge:
  - if flush_E, clear;
  - else if ~stall_E, load the D values;
  - else hold.
  - Flush has priority over stall.
- Outputs from D/E:
  - pred_take_E = pred_E.
  - pre_right = branch_E & valid_E & (pred_E == actual_take_E). Combinational.
- Training happens when RUN & branch_E & valid_E & ~stall_E, so each branch trains exactly once. On training:
  - Counter at PHT[idx_E]: +1 if actual_take_E, saturating at 2'b11; -1 if not taken, saturating at 2'b00.
  - GHR <= {GHR[GHR_W-2:0], actual_take_E}.
- Same-cycle read/write of the same index: pred_take_F uses the pre-update counter (read-old). The new value is visible the following cycle.
- GHR is non-speculative: updated only at E training. The idx_F computed in a training cycle uses the old GHR.
- Counters are 2 bits wide; no other arithmetic. init_ptr is IDX_W bits and does not wrap back into INIT.

Test Plan:
- Reset sequence, IDX_W=4: hold rst=0 for 2 cycles, release -> init_busy=1 for exactly 16 cycles, then 0. Every entry reads 2'b01; pred_take_F=0 with branch_F=1.
- Saturation: same PC 0x3000, GHR_W=1, train taken 4 times with no intervening E branches -> counter 01->10->11->11. pred_take_F=1 from the 2nd training onward (when GHR matches). Then train not-taken 3 times -> 11->10->01->00.
- Misprediction: predict not-taken (counter 01), branch reaches E with actual_take_E=1 -> pre_right=0, pred_take_E=0, counter becomes 10, GHR LSB becomes 1.
- Correct prediction: counter 11 -> pred_take_E=1 with actual_take_E=1 -> pre_right=1, counter stays 11.
- Stall/flush: stall_E=1 for 3 cycles with branch_E=1 -> pre_right held stable, no counter change until stall_E drops, then exactly one update. flush_E=1 together with stall_E=1 -> valid_E=0, pre_right=0, no training.
- Collision: training write to index 5 (01->10) in the same cycle pc_F maps to index 5 -> pred_take_F=0 that cycle, 1 the next cycle.
- Mid-operation reset: assert rst=0 while branch_E=1 -> no training; init_busy=1 on the next cycle; the table is re-initialised to 01.
